display_scan_7seg: RTL and testbench
====================================

Name: display_scan_7seg

Overview:
Time-multiplexed 4-digit 7-segment scan driver. It sits directly downstream of the 7-segment selector logic and consumes its SEL7SEG gate and AC digit-enable mask. It rotates through four digits, applies an anti-ghosting blank interval before each digit, hex-decodes each nibble, and drives active-low anode and segment lines.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot, including blanking; must be >= 2.
BLANK_CYCLES, 500, blanked cycles at the start of each slot; must be >= 1 and < REFRESH_DIV.
CNT_W, 16, slot counter width; must hold REFRESH_DIV-1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
EN  in  1  scan enable
SEL7SEG  in  1  display gate from the selector; 1 = digits may light
AC  in  4  per-digit enable mask from the selector; AC[k]=1 allows digit k
DIGITS  in  16  four hex nibbles; DIGITS[4k+3:4k] is digit k
DP  in  4  decimal point request per digit, active-high
AN  out  4  anode drive, active-low, one-hot-low when lit
SEG  out  7  segments, active-low, SEG[0]=a … SEG[6]=g
DPO  out  1  decimal point, active-low
DIGIT_IDX  out  2  index of the current slot
FRAME_TICK  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (async, active-high): AN=4'hF, SEG=7'h7F, DPO=1, DIGIT_IDX=0, FRAME_TICK=0. Slot counter=0. Snapshot registers=0. State=BLANK.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - OFF (EN=0).
  - BLANK (cnt < BLANK_CYCLES).
  - SHOW (BLANK_CYCLES <= cnt <= REFRESH_DIV-1).
- Slot counter cnt runs 0..REFRESH_DIV-1, then returns to 0. On that wrap, DIGIT_IDX increments mod 4 (3 -> 0).
- One frame = 4 slots = 4*REFRESH_DIV cycles.
- Frame start is the cycle with cnt=0 and idx=0:
  - DIGITS, DP, AC and SEL7SEG are captured into snapshot registers.
  - FRAME_TICK=1 for exactly that cycle.
  - Inputs changing mid-frame have no effect until the next frame (no tearing).
- BLANK: AN=4'hF, SEG=7'h7F, DPO=1.
- SHOW, with snapshot gate=1 and snapshot AC[idx]=1:
  - AN[idx]=0, all other anode bits 1.
  - SEG = hex decode of the snapshot nibble idx.
  - DPO = ~snapshot DP[idx].
- SHOW, with gate=0 or AC[idx]=0: outputs blank as in BLANK. The slot time is still consumed, so frame timing stays fixed.
- Hex decode table, SEG hex value (g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- EN=0 (synchronous):
  - Next edge enters OFF: outputs blank, cnt=0, idx=0, FRAME_TICK=0.
  - When EN returns to 1, the next edge starts a new frame: FRAME_TICK and snapshot in that cycle.
- After rst deasserts with EN=1, the first rising edge starts frame 0 (FRAME_TICK=1).
- Reset asserted mid-slot: outputs blank immediately (async), no partial digit remains.
- DIGIT_IDX always reflects the slot being timed, including BLANK and OFF (0 in OFF).
- Only one anode is ever low. AN=4'h0 or any two-low pattern is illegal.

Test Plan:
Use REFRESH_DIV=8, BLANK_CYCLES=2 for all scenarios.
1. Reset, then EN=1, SEL7SEG=1, AC=F, DIGITS=16'h1234, DP=0 -> FRAME_TICK at the first edge. Slot 0: 2 blank cycles, then 6 cycles of AN=E, SEG=19 (digit 4). Slots 1/2/3 follow with AN=D/30, B/24, 7/79. FRAME_TICK again 32 cycles later.
2. Change DIGITS to 16'hFFFF during slot 1 -> slots 2 and 3 still show 2 and 1. The next frame shows SEG=0E on all digits.
3. AC=4'b0101, DP=4'b0001 -> only slots 0 and 2 light. DPO=0 only in slot 0 SHOW. Frame period stays 32 cycles.
4. SEL7SEG=0 at frame start -> AN=F for the whole frame, while FRAME_TICK and DIGIT_IDX keep sequencing.
5. Drop EN in slot 2 cycle 5 -> next edge gives blank outputs and DIGIT_IDX=0. Raise EN after 3 cycles -> FRAME_TICK and a new slot 0.
6. Assert rst in slot 1 SHOW (not clock-aligned) -> AN=F and SEG=7F without waiting for an edge. After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/display_scan_7seg.sv
// ---------------------------------------------------------------------------
// display_scan_7seg
//
// Time-multiplexed scan driver for a 4-digit, active-low 7-segment display.
// Each digit owns one slot of REFRESH_DIV cycles. The first BLANK_CYCLES
// cycles of every slot are dark, which stops ghosting while the anodes
// switch. The gate, the digit mask, the nibbles and the decimal points are
// captured once per frame, so a frame never mixes old and new data.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   EN         scan enable (synchronous); low forces the display off
//   SEL7SEG    display gate from the selector, 1 = digits may light
//   AC[3:0]    per-digit enable mask, AC[k]=1 allows digit k
//   DIGITS     four hex nibbles, DIGITS[4k+3:4k] is digit k
//   DP[3:0]    decimal point request per digit, active-high
//   AN[3:0]    anode drive, active-low, at most one bit low
//   SEG[6:0]   segments a..g on SEG[0]..SEG[6], active-low
//   DPO        decimal point, active-low
//   DIGIT_IDX  index of the slot currently being timed
//   FRAME_TICK one-cycle pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module display_scan_7seg #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        SEL7SEG,
    input  logic [3:0]  AC,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DPO,
    output logic [1:0]  DIGIT_IDX,
    output logic        FRAME_TICK
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // Segment patterns for the hex digits, bit order g..a, active-low.
    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] pattern;
        case (nib)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       state_q, state_d;
    // Set after reset and while disabled: the next enabled edge opens a frame
    // at slot 0 instead of advancing the counter.
    logic             armed_q, armed_d;
    logic [15:0]      snapDigits_q, snapDigits_d;
    logic [3:0]       snapDp_q, snapDp_d;
    logic [3:0]       snapAc_q, snapAc_d;
    logic             snapGate_q, snapGate_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dpo_q, dpo_d;
    logic             tick_q, tick_d;

    logic             frameStart;
    logic             lit;
    logic [3:0]       nibble;

    // Slot/digit sequencing, frame snapshot and state selection.
    // Everything is computed for the cycle that follows the edge, so the
    // output registers below can be loaded directly from these values.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        armed_d      = armed_q;
        snapDigits_d = snapDigits_q;
        snapDp_d     = snapDp_q;
        snapAc_d     = snapAc_q;
        snapGate_d   = snapGate_q;
        frameStart   = 1'b0;
        state_d      = state_q;

        if (!EN) begin
            cnt_d   = '0;
            idx_d   = 2'd0;
            armed_d = 1'b1;
            state_d = ST_OFF;
        end else begin
            if (armed_q) begin
                cnt_d   = '0;
                idx_d   = 2'd0;
                armed_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            frameStart = (cnt_d == '0) && (idx_d == 2'd0);
            if (frameStart) begin
                snapDigits_d = DIGITS;
                snapDp_d     = DP;
                snapAc_d     = AC;
                snapGate_d   = SEL7SEG;
            end

            state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
        end
    end

    // Output decode. A slot that is masked or gated off stays dark but still
    // consumes its time so the frame period never changes.
    always_comb begin
        lit    = (state_d == ST_SHOW) && snapGate_d && snapAc_d[idx_d];
        nibble = snapDigits_d[{idx_d, 2'b00} +: 4];
        an_d   = 4'hF;
        seg_d  = 7'h7F;
        dpo_d  = 1'b1;
        tick_d = frameStart;
        if (lit) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = hexToSeg(nibble);
            dpo_d = ~snapDp_d[idx_d];
        end
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            state_q      <= ST_BLANK;
            armed_q      <= 1'b1;
            snapDigits_q <= '0;
            snapDp_q     <= '0;
            snapAc_q     <= '0;
            snapGate_q   <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dpo_q        <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            armed_q      <= armed_d;
            snapDigits_q <= snapDigits_d;
            snapDp_q     <= snapDp_d;
            snapAc_q     <= snapAc_d;
            snapGate_q   <= snapGate_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dpo_q        <= dpo_d;
            tick_q       <= tick_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DPO        = dpo_q;
    assign DIGIT_IDX  = idx_q;
    assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_display_scan_7seg.sv
// ---------------------------------------------------------------------------
// tb_display_scan_7seg
//
// Self-checking bench for display_scan_7seg with REFRESH_DIV=8 and
// BLANK_CYCLES=2. The reference model tracks the position inside a 32-cycle
// frame as a single integer (-1 while reset or disabled) and derives the
// slot, blanking and lit digit from it arithmetically.
// ---------------------------------------------------------------------------
module tb_display_scan_7seg;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst;
    logic        EN;
    logic        SEL7SEG;
    logic [3:0]  AC;
    logic [15:0] DIGITS;
    logic [3:0]  DP;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DPO;
    logic [1:0]  DIGIT_IDX;
    logic        FRAME_TICK;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int          pos = -1;
    logic [15:0] mDigits = '0;
    logic [3:0]  mDp = '0;
    logic [3:0]  mAc = '0;
    logic        mGate = 1'b0;

    logic [6:0] hexTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display_scan_7seg #(
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .EN        (EN),
        .SEL7SEG   (SEL7SEG),
        .AC        (AC),
        .DIGITS    (DIGITS),
        .DP        (DP),
        .AN        (AN),
        .SEG       (SEG),
        .DPO       (DPO),
        .DIGIT_IDX (DIGIT_IDX),
        .FRAME_TICK(FRAME_TICK)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {AN, SEG, DPO, DIGIT_IDX, FRAME_TICK} of what the model predicts.
    function automatic logic [14:0] expected();
        int slot;
        int off;
        logic show;
        logic [3:0] an;
        logic [6:0] seg;
        logic dpo;
        if (pos < 0) return {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
        slot = pos / DIV;
        off  = pos % DIV;
        show = (off >= BLANK) && mGate && mAc[slot];
        an   = 4'hF;
        seg  = 7'h7F;
        dpo  = 1'b1;
        if (show) begin
            an[slot] = 1'b0;
            seg = hexTab[(mDigits >> (4 * slot)) & 16'hF];
            dpo = ~mDp[slot];
        end
        return {an, seg, dpo, 2'(slot), pos == 0};
    endfunction

    function automatic logic [14:0] observed();
        return {AN, SEG, DPO, DIGIT_IDX, FRAME_TICK};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then
    // settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (!EN) begin
                pos = -1;
            end else begin
                pos = (pos < 0) ? 0 : (pos + 1) % FRAME;
                if (pos == 0) begin
                    mDigits = DIGITS;
                    mDp     = DP;
                    mAc     = AC;
                    mGate   = SEL7SEG;
                end
            end
        end
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic gate, input logic [3:0] ac,
                                 input logic [15:0] digits, input logic [3:0] dp);
        EN      = en;
        SEL7SEG = gate;
        AC      = ac;
        DIGITS  = digits;
        DP      = dp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'hF, 16'h1234, 4'h0);
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (observed() !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL reset c=%0d got %h want %h", c, observed(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
            end
            tick();
        end
        #2;
        rst = 1'b0;
        pos = -1;
    endtask

    task automatic test_scan();
        // 1234 frame, then one frame of random data with random points.
        for (int c = 0; c < FRAME + 1; c++) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL scan pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
        applyStimulus(1'b1, 1'b1, 4'hF, 16'($urandom), 4'($urandom));
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL scan_rand pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
    endtask

    task automatic test_no_tearing();
        for (int c = 0; c < 2 * FRAME && pos != FRAME - 1; c++) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL tear_align pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
        if (pos != FRAME - 1) begin
            miscompares++;
            $display("[TB] FAIL tear_align timeout pos=%0d want %0d", pos, FRAME - 1);
        end
        applyStimulus(1'b1, 1'b1, 4'hF, 16'h1234, 4'h0);
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (pos == DIV + 1) DIGITS = 16'hFFFF;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL no_tearing pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
    endtask

    task automatic test_mask();
        for (int f = 0; f < 4; f++) begin
            if (f == 0) applyStimulus(1'b1, 1'b1, 4'b0101, 16'($urandom), 4'b0001);
            else        applyStimulus(1'b1, 1'b1, 4'($urandom), 16'($urandom), 4'($urandom));
            for (int c = 0; c < FRAME; c++) begin
                tick();
                vectors++;
                if (observed() !== expected()) begin
                    miscompares++;
                    $display("[TB] FAIL mask f=%0d pos=%0d got %h want %h", f, pos, observed(), expected());
                end
            end
        end
    endtask

    task automatic test_gate();
        applyStimulus(1'b1, 1'b0, 4'hF, 16'($urandom), 4'hF);
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (c == FRAME - 1) SEL7SEG = 1'b1;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL gate pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
    endtask

    task automatic test_enable();
        for (int c = 0; c < 2 * FRAME && pos != 2 * DIV + 5; c++) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL en_align pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
        if (pos != 2 * DIV + 5) begin
            miscompares++;
            $display("[TB] FAIL en_align timeout pos=%0d want %0d", pos, 2 * DIV + 5);
        end
        EN = 1'b0;
        for (int c = 0; c < 3 + FRAME + 1; c++) begin
            tick();
            if (c == 2) EN = 1'b1;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL enable c=%0d pos=%0d got %h want %h", c, pos, observed(), expected());
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 2 * FRAME && pos != DIV + 4; c++) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL rst_align pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
        if (pos != DIV + 4) begin
            miscompares++;
            $display("[TB] FAIL rst_align timeout pos=%0d want %0d", pos, DIV + 4);
        end
        #2;
        rst = 1'b1;
        pos = -1;
        mDigits = '0;
        mDp = '0;
        mAc = '0;
        mGate = 1'b0;
        #1;
        vectors++;
        if (observed() !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset got %h want %h", observed(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        tick();
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'hF, 16'h1234, 4'h0);
        for (int c = 0; c < FRAME + 1; c++) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL after_reset pos=%0d got %h want %h", pos, observed(), expected());
            end
        end
    endtask

    task automatic test_back_to_back();
        // Inputs churn every cycle; EN drops occasionally.
        for (int c = 0; c < 300; c++) begin
            applyStimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                          4'($urandom), 16'($urandom), 4'($urandom));
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL random c=%0d pos=%0d got %h want %h", c, pos, observed(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_mask();
        test_gate();
        test_enable();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
